path_node_sequencer: RTL and testbench

//  Downstream of the Dijkstra handler. Latches each route request (CPU_start/start_point/end_point), fetches
//  the node list from the path planner, and hands nodes one at a time to the line follower.

---
 rtl/path_node_sequencer.sv | 169 ++++++++++++++++
 tb/tb_path_node_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_node_sequencer.sv
// Route sequencer between the Dijkstra handler, the path planner and the line follower.
// Optional planner-response timeout is built when PLAN_TIMEOUT_EN is defined.
module path_node_sequencer #(
  parameter int PATH_DEPTH     = 32,
  parameter int START_NODE     = 0,
  parameter int TIMEOUT_CYCLES = 3125
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       CPU_start,
  input  logic [4:0] start_point,
  input  logic [4:0] end_point,
  output logic       plan_req,
  output logic [4:0] plan_src,
  output logic [4:0] plan_dst,
  input  logic       path_valid,
  input  logic [4:0] path_node,
  input  logic       path_last,
  output logic       path_ready,
  input  logic       node_reached,
  output logic       target_valid,
  output logic [4:0] realtime_pos,
  output logic [4:0] curr_node,
  output logic       path_done,
  output logic       plan_err,
  output logic       busy
);
  // state | meaning
  // IDLE  | waiting for a request whose destination differs from curr_node
  // REQ   | plan_req pulse to the planner
  // LOAD  | buffering the planner node stream until path_last
  // RUN   | handing nodes to the follower, one per node_reached
  // DONE  | path_done pulse
  localparam int AW = $clog2(PATH_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] START = 5'(START_NODE);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, RUN, DONE} state_t;
  state_t state;

  logic [4:0]    mem [PATH_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          first_pend;
  logic          full, empty, accept, drop, wr_en, rd_en;
  logic          abort, overflow, timeout, flush;

  assign full       = (count == CW'(PATH_DEPTH));
  assign empty      = (count == '0);
  assign path_ready = (state == LOAD) && !full;
  assign busy       = (state != IDLE);
  assign accept     = path_valid && path_ready;
  assign drop       = first_pend && (path_node == plan_src);
  assign abort      = !CPU_start && (state == REQ || state == LOAD || state == RUN);
  assign overflow   = !abort && (state == LOAD) && path_valid && full;
  assign wr_en      = !abort && accept && !drop;
  // First RUN cycle loads the head; afterwards each junction pops the next node
  assign rd_en      = !abort && (state == RUN) && !empty && (!target_valid || node_reached);

`ifdef PLAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;

  assign timeout = !abort && (state == LOAD) && !path_valid && (timer == '0);

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (state == REQ || accept)
      timer <= TW'(TIMEOUT_CYCLES - 1);
    else if (state == LOAD && timer != '0)
      timer <= timer - TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  assign flush = abort || overflow || timeout;

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (wr_en) mem[wr_ptr] <= path_node;
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      plan_req     <= 1'b0;
      plan_src     <= '0;
      plan_dst     <= '0;
      target_valid <= 1'b0;
      realtime_pos <= START;
      curr_node    <= START;
      path_done    <= 1'b0;
      plan_err     <= 1'b0;
      first_pend   <= 1'b0;
    end else begin
      plan_req  <= 1'b0;
      path_done <= 1'b0;
      if (flush) begin
        state        <= IDLE;
        target_valid <= 1'b0;
        if (overflow || timeout) plan_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (CPU_start && end_point != curr_node) begin
              plan_src <= start_point;
              plan_dst <= end_point;
              plan_err <= 1'b0;
              plan_req <= 1'b1;
              state    <= REQ;
            end
          end
          REQ: begin
            first_pend <= 1'b1;
            state      <= LOAD;
          end
          LOAD: begin
            if (accept) begin
              first_pend <= 1'b0;
              if (path_last) begin
                // Path consisting of the source alone: nothing to drive to
                if (empty && drop) begin
                  state     <= DONE;
                  path_done <= 1'b1;
                end else begin
                  state <= RUN;
                end
              end
            end
          end
          RUN: begin
            if (!target_valid) begin
              realtime_pos <= mem[rd_ptr];
              target_valid <= 1'b1;
            end else if (node_reached) begin
              curr_node <= realtime_pos;
              if (!empty) begin
                realtime_pos <= mem[rd_ptr];
              end else begin
                target_valid <= 1'b0;
                path_done    <= 1'b1;
                state        <= DONE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_path_node_sequencer.sv
// Bench for path_node_sequencer: queue-based route model checked every cycle, plus directed
// route / abort / overflow / timeout / reset scenarios and randomized routes.
module tb_path_node_sequencer;
  localparam int DEPTH = 32;
  localparam int TMO   = 3125;
`ifdef PLAN_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk_3125KHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       CPU_start = 1'b0;
  logic [4:0] start_point = '0;
  logic [4:0] end_point = '0;
  logic       plan_req;
  logic [4:0] plan_src, plan_dst;
  logic       path_valid = 1'b0;
  logic [4:0] path_node = '0;
  logic       path_last = 1'b0;
  logic       path_ready;
  logic       node_reached = 1'b0;
  logic       target_valid;
  logic [4:0] realtime_pos, curr_node;
  logic       path_done, plan_err, busy;

  path_node_sequencer dut (
    .clk_3125KHz(clk_3125KHz), .rst_n(rst_n), .CPU_start(CPU_start),
    .start_point(start_point), .end_point(end_point),
    .plan_req(plan_req), .plan_src(plan_src), .plan_dst(plan_dst),
    .path_valid(path_valid), .path_node(path_node), .path_last(path_last),
    .path_ready(path_ready), .node_reached(node_reached),
    .target_valid(target_valid), .realtime_pos(realtime_pos), .curr_node(curr_node),
    .path_done(path_done), .plan_err(plan_err), .busy(busy)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: route phase, node queue, observable outputs
  int         m_mode;   // 0 idle, 1 request, 2 loading, 3 driving, 4 finished
  int         m_q[$];
  bit         m_first, m_tv, m_req, m_done, m_err;
  logic [4:0] m_pos, m_curr, m_src, m_dst;
  int         m_wait;

  always @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_q.delete(); m_first = 0; m_tv = 0; m_req = 0; m_done = 0; m_err = 0;
      m_pos = 0; m_curr = 0; m_src = 0; m_dst = 0; m_wait = 0;
    end else begin
      m_req = 0;
      m_done = 0;
      if (!CPU_start && m_mode >= 1 && m_mode <= 3) begin
        m_q.delete(); m_tv = 0; m_mode = 0;
      end else begin
        case (m_mode)
          0: if (CPU_start && end_point != m_curr) begin
               m_src = start_point; m_dst = end_point; m_err = 0; m_req = 1; m_mode = 1;
             end
          1: begin m_mode = 2; m_first = 1; m_wait = 0; end
          2: begin
               if (path_valid && m_q.size() == DEPTH) begin
                 m_err = 1; m_q.delete(); m_mode = 0;
               end else if (path_valid) begin
                 if (!(m_first && path_node == m_src)) m_q.push_back(int'(path_node));
                 m_first = 0;
                 m_wait = 0;
                 if (path_last) begin
                   if (m_q.size() == 0) begin m_mode = 4; m_done = 1; end
                   else m_mode = 3;
                 end
               end else begin
                 m_wait++;
                 if (TMO_ON && m_wait >= TMO) begin m_err = 1; m_q.delete(); m_mode = 0; end
               end
             end
          3: begin
               if (!m_tv) begin
                 m_pos = 5'(m_q.pop_front()); m_tv = 1;
               end else if (node_reached) begin
                 m_curr = m_pos;
                 if (m_q.size() > 0) m_pos = 5'(m_q.pop_front());
                 else begin m_tv = 0; m_mode = 4; m_done = 1; end
               end
             end
          default: m_mode = 0;
        endcase
      end
    end
  end

  always @(negedge clk_3125KHz) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(m_mode != 0));
      chk("path_ready", int'(path_ready), int'(m_mode == 2 && m_q.size() < DEPTH));
      chk("plan_req", int'(plan_req), int'(m_req));
      chk("path_done", int'(path_done), int'(m_done));
      chk("target_valid", int'(target_valid), int'(m_tv));
      chk("realtime_pos", int'(realtime_pos), int'(m_pos));
      chk("curr_node", int'(curr_node), int'(m_curr));
      chk("plan_err", int'(plan_err), int'(m_err));
      chk("plan_src", int'(plan_src), int'(m_src));
      chk("plan_dst", int'(plan_dst), int'(m_dst));
    end
  end

  // Planner / follower stimulus state and directed-test observations
  int         stream[$];
  bit         with_last, gaps, fol_auto, streaming, ready_drv, tv_seen;
  int         idx;
  int         n_req, n_done, first_target;
  int         curr_hist[$];
  logic [4:0] last_curr;

  task automatic step();
    @(negedge clk_3125KHz);
    if (plan_req) n_req++;
    if (path_done) n_done++;
    if (curr_node != last_curr) begin curr_hist.push_back(int'(curr_node)); last_curr = curr_node; end
    if (target_valid && !tv_seen) begin tv_seen = 1; first_target = int'(realtime_pos); end
    if (plan_req) begin streaming = 1; idx = 0; end
    else if (path_valid && ready_drv) begin idx++; if (path_last) streaming = 0; end
    if (!busy) streaming = 0;
    if (streaming && idx < stream.size() && (!gaps || $urandom_range(3, 0) != 0)) begin
      path_valid = 1;
      path_node  = 5'(stream[idx]);
      path_last  = with_last && (idx == stream.size() - 1);
    end else begin
      path_valid = 0;
      path_node  = 5'($urandom_range(31, 0));
      path_last  = 0;
    end
    ready_drv = path_ready;
    if (fol_auto) node_reached = target_valid ? ($urandom_range(2, 0) == 0) : ($urandom_range(9, 0) == 0);
    else node_reached = 0;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    step();
    while (busy && n < budget) begin step(); n++; end
    chk({name, "_ends_idle"}, int'(busy), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    last_curr = '0; fol_auto = 1; gaps = 0; with_last = 1;
    streaming = 0; ready_drv = 0; tv_seen = 0; idx = 0;
    n_req = 0; n_done = 0; first_target = -1;

    // Reset values
    repeat (3) step();
    chk("rst_curr_node", int'(curr_node), 0);
    chk("rst_realtime_pos", int'(realtime_pos), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_target_valid", int'(target_valid), 0);
    chk("rst_plan_req", int'(plan_req), 0);
    rst_n = 1;
    step();

    // Route 0 -> 24 through 1 and 30; node 0 dropped
    stream = '{0, 1, 30, 24}; with_last = 1;
    n_req = 0; n_done = 0; curr_hist.delete(); tv_seen = 0;
    start_point = 5'd0; end_point = 5'd24; CPU_start = 1;
    run_until_idle(500, "route_0_24");
    chk("route_plan_req_count", n_req, 1);
    chk("route_first_target", first_target, 1);
    chk("route_hist_len", curr_hist.size(), 3);
    chk("route_hist_0", curr_hist[0], 1);
    chk("route_hist_1", curr_hist[1], 30);
    chk("route_hist_2", curr_hist[2], 24);
    chk("route_done_count", n_done, 1);

    // Already at destination with CPU_start still high
    n_req = 0; n_done = 0;
    repeat (20) step();
    chk("there_plan_req_count", n_req, 0);
    chk("there_done_count", n_done, 0);
    chk("there_busy", int'(busy), 0);

    // Back to node 0, then abort on the way to 24
    stream = '{24, 30, 1, 0};
    start_point = 5'd24; end_point = 5'd0;
    run_until_idle(500, "route_24_0");
    chk("route_24_0_curr", int'(curr_node), 0);
    CPU_start = 0;
    step();
    fol_auto = 0;
    stream = '{0, 1, 30, 24};
    start_point = 5'd0; end_point = 5'd24; CPU_start = 1;
    n = 0;
    step();
    while (!(target_valid && realtime_pos == 5'd1) && n < 200) begin step(); n++; end
    chk("abort_first_target", int'(target_valid && realtime_pos == 5'd1), 1);
    node_reached = 1;
    step();
    chk("abort_pos_30", int'(realtime_pos), 30);
    CPU_start = 0;
    step();
    chk("abort_busy", int'(busy), 0);
    chk("abort_target_valid", int'(target_valid), 0);
    chk("abort_curr_node", int'(curr_node), 1);
    chk("abort_pos_held", int'(realtime_pos), 30);
    fol_auto = 1;
    step();

    // Overflow: 33 nodes, no path_last
    stream.delete();
    for (int i = 0; i < 33; i++) stream.push_back((i + 2) % 32);
    with_last = 0;
    start_point = 5'd1; end_point = 5'd5; CPU_start = 1;
    run_until_idle(400, "overflow");
    chk("overflow_plan_err", int'(plan_err), 1);
    CPU_start = 0;
    step();

    // Short route after overflow: stale FIFO contents would show up here
    stream = '{1, 3}; with_last = 1;
    start_point = 5'd1; end_point = 5'd3; CPU_start = 1;
    run_until_idle(300, "after_overflow");
    chk("after_overflow_curr", int'(curr_node), 3);
    chk("after_overflow_err_cleared", int'(plan_err), 0);
    CPU_start = 0;
    step();

    // Silent planner
    stream.delete();
    start_point = 5'd3; end_point = 5'd7; CPU_start = 1;
    n = 0;
    step();
`ifdef PLAN_TIMEOUT_EN
    while (busy && n < 4000) begin step(); n++; end
    chk("timeout_cycles", n, TMO + 1);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_plan_err", int'(plan_err), 1);
`else
    repeat (10000) step();
    chk("no_timeout_busy", int'(busy), 1);
    chk("no_timeout_loading", int'(path_ready), 1);
    chk("no_timeout_plan_err", int'(plan_err), 0);
`endif
    CPU_start = 0;
    step();

    // Randomized routes with gaps, spurious follower pulses and occasional aborts
    gaps = 1; fol_auto = 1;
    for (int r = 0; r < 50; r++) begin
      start_point = 5'($urandom_range(31, 0));
      end_point   = 5'($urandom_range(31, 0));
      with_last   = ($urandom_range(7, 0) != 0);
      len = with_last ? $urandom_range(8, 1) : $urandom_range(36, 34);
      stream.delete();
      for (int i = 0; i < len; i++) begin
        if (i == 0 && $urandom_range(1, 0) == 1) stream.push_back(int'(start_point));
        else if (i == len - 1) stream.push_back(int'(end_point));
        else stream.push_back($urandom_range(31, 0));
      end
      CPU_start = 1;
      n = 0;
      step();
      while (busy && n < 1000) begin
        if ($urandom_range(299, 0) == 0) CPU_start = 0;
        step();
        n++;
      end
      chk("rand_route_ends_idle", int'(busy), 0);
      CPU_start = 0;
      step();
    end

    // Asynchronous reset in the middle of a route
    fol_auto = 0; gaps = 0; with_last = 1;
    end_point = (curr_node == 5'd20) ? 5'd21 : 5'd20;
    start_point = curr_node;
    stream = '{10, int'(end_point)};
    CPU_start = 1;
    n = 0;
    step();
    while (!target_valid && n < 200) begin step(); n++; end
    chk("midreset_target_live", int'(target_valid), 1);
    rst_n = 0;
    #1;
    chk("midreset_curr_node", int'(curr_node), 0);
    chk("midreset_realtime_pos", int'(realtime_pos), 0);
    chk("midreset_target_valid", int'(target_valid), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_plan_dst", int'(plan_dst), 0);
    CPU_start = 0;
    step();
    step();
    rst_n = 1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
